// File: rtl/spi_slave_fifo_core.sv
// spi_slave_fifo_core
// SPI slave with TX and RX FIFOs for CS-framed multi-word bursts. Supports
// all four CPOL/CPHA modes and MSB- or LSB-first ordering. The SPI pins are
// oversampled in the system clock domain. Overflow, underflow and truncated
// frames are flagged with single-cycle pulses.
module spi_slave_fifo_core #(
  parameter int DATA_WIDTH  = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          i_sys_clk,
  input  logic                          i_sys_rst_n,
  input  logic                          i_spi_sclk,
  input  logic                          i_spi_mosi,
  output logic                          o_spi_miso,
  input  logic                          i_spi_cs_n,
  input  logic                          i_cpol,
  input  logic                          i_cpha,
  input  logic                          i_lsb_first,
  input  logic [DATA_WIDTH-1:0]         i_tx_data,
  input  logic                          i_tx_valid,
  output logic                          o_tx_ready,
  output logic [DATA_WIDTH-1:0]         o_rx_data,
  output logic                          o_rx_valid,
  input  logic                          i_rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_tx_level,
  output logic [$clog2(FIFO_DEPTH):0]   o_rx_level,
  output logic                          o_tx_underflow,
  output logic                          o_rx_overflow,
  output logic                          o_frame_err,
  output logic                          o_spi_active
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W:0]   PTR_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   PTR_DEPTH = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } frame_state_t;

  frame_state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, mosi_s, cs_s;
  logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

  logic                   cpol_q, cpha_q, lsb_q;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic                   reload_pending_q;
  logic                   seen_sample_q;
  logic [DATA_WIDTH-1:0]  tx_sh_q, rx_sh_q;

  logic                   frame_start, frame_end, in_frame;
  logic                   lead_edge, trail_edge;
  logic                   sample_evt, shift_evt, word_done, tx_load;
  logic [DATA_WIDTH-1:0]  rx_next, tx_shifted, tx_load_word;

  logic [DATA_WIDTH-1:0]  tx_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]  rx_mem [FIFO_DEPTH];
  logic [PTR_W:0]         tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic                   tx_full, tx_empty, rx_full, rx_empty;
  logic                   tx_wr, tx_pop, rx_push, rx_wr, rx_pop;

  // Bring the SPI pins into the system clock domain and keep one extra
  // copy of SCLK and CS_n for edge detection.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_spi_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_spi_cs_n};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;

  // Frame state register.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame sequencing: open on a synced CS fall, close on a synced CS rise.
  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d     = ST_ACTIVE;
          frame_start = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise) begin
          state_d   = ST_IDLE;
          frame_end = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Classify SCLK edges into sample and shift events for the latched mode;
  // shift edges before the first sample of a frame are suppressed.
  always_comb begin
    lead_edge    = cpol_q ? sclk_fall : sclk_rise;
    trail_edge   = cpol_q ? sclk_rise : sclk_fall;
    in_frame     = (state_q == ST_ACTIVE) && !frame_end;
    sample_evt   = in_frame && (cpha_q ? trail_edge : lead_edge);
    shift_evt    = in_frame && seen_sample_q && (cpha_q ? lead_edge : trail_edge);
    word_done    = sample_evt && (bit_cnt_q == CNT_LAST);
    tx_load      = frame_start || (shift_evt && reload_pending_q);
    rx_next      = lsb_q ? {mosi_s, rx_sh_q[DATA_WIDTH-1:1]}
                         : {rx_sh_q[DATA_WIDTH-2:0], mosi_s};
    tx_shifted   = lsb_q ? {1'b0, tx_sh_q[DATA_WIDTH-1:1]}
                         : {tx_sh_q[DATA_WIDTH-2:0], 1'b0};
    tx_load_word = tx_empty ? '0 : tx_mem[tx_rd_ptr[PTR_W-1:0]];
  end

  // Shift registers, bit counter and per-frame mode latch.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      cpol_q           <= 1'b0;
      cpha_q           <= 1'b0;
      lsb_q            <= 1'b0;
      bit_cnt_q        <= '0;
      reload_pending_q <= 1'b0;
      seen_sample_q    <= 1'b0;
      tx_sh_q          <= '0;
      rx_sh_q          <= '0;
    end else if (frame_start) begin
      cpol_q           <= i_cpol;
      cpha_q           <= i_cpha;
      lsb_q            <= i_lsb_first;
      bit_cnt_q        <= '0;
      reload_pending_q <= 1'b0;
      seen_sample_q    <= 1'b0;
      rx_sh_q          <= '0;
      tx_sh_q          <= tx_load_word;
    end else if (frame_end) begin
      bit_cnt_q        <= '0;
      reload_pending_q <= 1'b0;
      seen_sample_q    <= 1'b0;
      rx_sh_q          <= '0;
      tx_sh_q          <= '0;
    end else if (sample_evt) begin
      rx_sh_q       <= rx_next;
      seen_sample_q <= 1'b1;
      if (word_done) begin
        bit_cnt_q        <= '0;
        reload_pending_q <= 1'b1;
      end else begin
        bit_cnt_q <= bit_cnt_q + CNT_ONE;
      end
    end else if (shift_evt) begin
      if (reload_pending_q) begin
        tx_sh_q          <= tx_load_word;
        reload_pending_q <= 1'b0;
      end else begin
        tx_sh_q <= tx_shifted;
      end
    end
  end

  assign o_spi_active = (state_q == ST_ACTIVE);
  assign o_spi_miso   = o_spi_active ? (lsb_q ? tx_sh_q[0] : tx_sh_q[DATA_WIDTH-1]) : 1'b0;

  assign tx_empty   = (tx_wr_ptr == tx_rd_ptr);
  assign tx_full    = (o_tx_level == PTR_DEPTH);
  assign o_tx_level = tx_wr_ptr - tx_rd_ptr;
  assign o_tx_ready = !tx_full;
  assign tx_wr      = i_tx_valid && !tx_full;
  assign tx_pop     = tx_load && !tx_empty;

  // TX FIFO storage.
  always_ff @(posedge i_sys_clk) begin
    if (tx_wr) begin
      tx_mem[tx_wr_ptr[PTR_W-1:0]] <= i_tx_data;
    end
  end

  // TX FIFO pointers: host-side writes, SPI-side pops on load/reload.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
    end else begin
      if (tx_wr) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
      if (tx_pop) tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
    end
  end

  assign rx_empty   = (rx_wr_ptr == rx_rd_ptr);
  assign rx_full    = (o_rx_level == PTR_DEPTH);
  assign o_rx_level = rx_wr_ptr - rx_rd_ptr;
  assign o_rx_valid = !rx_empty;
  assign o_rx_data  = rx_empty ? '0 : rx_mem[rx_rd_ptr[PTR_W-1:0]];
  assign rx_push    = word_done;
  assign rx_pop     = i_rx_ready && !rx_empty;
  assign rx_wr      = rx_push && (!rx_full || rx_pop);

  // RX FIFO storage; a full FIFO still accepts a word when a read frees a slot.
  always_ff @(posedge i_sys_clk) begin
    if (rx_wr) begin
      rx_mem[rx_wr_ptr[PTR_W-1:0]] <= rx_next;
    end
  end

  // RX FIFO pointers: SPI-side pushes, host-side reads.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
    end else begin
      if (rx_wr) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
      if (rx_pop) rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
    end
  end

  // Single-cycle status pulses.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      o_tx_underflow <= 1'b0;
      o_rx_overflow  <= 1'b0;
      o_frame_err    <= 1'b0;
    end else begin
      o_tx_underflow <= tx_load && tx_empty;
      o_rx_overflow  <= rx_push && rx_full && !rx_pop;
      o_frame_err    <= frame_end && (bit_cnt_q != '0);
    end
  end

endmodule

// File: tb/tb_spi_slave_fifo_core.sv
// tb_spi_slave_fifo_core
// Drives SPI frames from a behavioural host and checks the slave against a
// word-level reference model built from FIFO queues.
module tb_spi_slave_fifo_core;

  localparam int W     = 16;
  localparam int DEPTH = 8;
  localparam int SYNC  = 2;
  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int HALF  = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_spi_sclk = 1'b0;
  logic             i_spi_mosi = 1'b0;
  logic             i_spi_cs_n = 1'b1;
  logic             i_cpol = 1'b0;
  logic             i_cpha = 1'b0;
  logic             i_lsb_first = 1'b0;
  logic [W-1:0]     i_tx_data = '0;
  logic             i_tx_valid = 1'b0;
  logic             i_rx_ready = 1'b0;
  logic             o_spi_miso, o_tx_ready, o_rx_valid;
  logic [W-1:0]     o_rx_data;
  logic [LVL_W-1:0] o_tx_level, o_rx_level;
  logic             o_tx_underflow, o_rx_overflow, o_frame_err, o_spi_active;

  always #5 clk = ~clk;

  spi_slave_fifo_core #(
    .DATA_WIDTH (W),
    .FIFO_DEPTH (DEPTH),
    .SYNC_STAGES(SYNC)
  ) dut (
    .i_sys_clk     (clk),
    .i_sys_rst_n   (rst_n),
    .i_spi_sclk    (i_spi_sclk),
    .i_spi_mosi    (i_spi_mosi),
    .o_spi_miso    (o_spi_miso),
    .i_spi_cs_n    (i_spi_cs_n),
    .i_cpol        (i_cpol),
    .i_cpha        (i_cpha),
    .i_lsb_first   (i_lsb_first),
    .i_tx_data     (i_tx_data),
    .i_tx_valid    (i_tx_valid),
    .o_tx_ready    (o_tx_ready),
    .o_rx_data     (o_rx_data),
    .o_rx_valid    (o_rx_valid),
    .i_rx_ready    (i_rx_ready),
    .o_tx_level    (o_tx_level),
    .o_rx_level    (o_rx_level),
    .o_tx_underflow(o_tx_underflow),
    .o_rx_overflow (o_rx_overflow),
    .o_frame_err   (o_frame_err),
    .o_spi_active  (o_spi_active)
  );

  int vectors = 0;
  int miscompares = 0;
  int n_under = 0, n_over = 0, n_ferr = 0;
  int exp_under, exp_over, exp_ferr;

  logic [W-1:0] tx_model[$];
  logic [W-1:0] rx_model[$];
  logic [W-1:0] exp_cap[$];
  logic [W-1:0] host_rx[$];
  logic [W-1:0] frame_words[$];

  // Count status pulses between clock edges.
  always @(negedge clk) begin
    if (o_tx_underflow) n_under++;
    if (o_rx_overflow)  n_over++;
    if (o_frame_err)    n_ferr++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write one word into the TX FIFO.
  task automatic applyStimulus(input logic [W-1:0] w);
    @(negedge clk);
    checkOutput("tx_ready", o_tx_ready, tx_model.size() < DEPTH);
    i_tx_data  = w;
    i_tx_valid = 1'b1;
    @(negedge clk);
    i_tx_valid = 1'b0;
    if (tx_model.size() < DEPTH) tx_model.push_back(w);
  endtask

  // Behavioural SPI host: sends frame_words, captures MISO words into host_rx.
  task automatic hostFrame(input bit cpol, input bit cpha, input bit lsb, input int nbits);
    logic [W-1:0] cap;
    logic [W-1:0] w;
    int pos;
    @(negedge clk);
    i_cpol = cpol; i_cpha = cpha; i_lsb_first = lsb;
    i_spi_sclk = cpol; i_spi_mosi = 1'b0;
    repeat (HALF) @(negedge clk);
    i_spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    cap = '0;
    for (int b = 0; b < nbits; b++) begin
      w   = frame_words[b / W];
      pos = b % W;
      if (!cpha) begin
        i_spi_mosi = lsb ? w[pos] : w[W-1-pos];
        repeat (HALF) @(negedge clk);
        if (lsb) cap[pos] = o_spi_miso; else cap[W-1-pos] = o_spi_miso;
        i_spi_sclk = ~cpol;
        repeat (HALF) @(negedge clk);
        i_spi_sclk = cpol;
      end else begin
        i_spi_sclk = ~cpol;
        i_spi_mosi = lsb ? w[pos] : w[W-1-pos];
        repeat (HALF) @(negedge clk);
        if (lsb) cap[pos] = o_spi_miso; else cap[W-1-pos] = o_spi_miso;
        i_spi_sclk = cpol;
        repeat (HALF) @(negedge clk);
      end
      if (pos == W - 1) host_rx.push_back(cap);
    end
    repeat (HALF) @(negedge clk);
    i_spi_cs_n = 1'b1;
    repeat (4 * HALF) @(negedge clk);
  endtask

  // Word-level prediction of one frame: which TX words get loaded, what the
  // host sees, what lands in the RX FIFO and which flags fire.
  task automatic modelFrame(input bit cpha, input int nbits);
    int completed;
    int loads;
    logic [W-1:0] v;
    completed = nbits / W;
    loads = 1;
    for (int k = 0; k < completed; k++)
      if (!cpha || (k + 1) * W < nbits) loads++;
    exp_cap.delete();
    for (int k = 0; k < loads; k++) begin
      if (tx_model.size() == 0) begin
        exp_under++;
        v = '0;
      end else begin
        v = tx_model.pop_front();
      end
      if (k < completed) exp_cap.push_back(v);
    end
    for (int k = 0; k < completed; k++) begin
      if (rx_model.size() < DEPTH) rx_model.push_back(frame_words[k]);
      else exp_over++;
    end
    if (nbits % W != 0) exp_ferr++;
  endtask

  task automatic drainRx(input string tag);
    logic [W-1:0] e;
    while (rx_model.size() > 0) begin
      e = rx_model.pop_front();
      checkOutput({tag, "/rx_valid"}, o_rx_valid, 1);
      checkOutput({tag, "/rx_data"}, o_rx_data, e);
      i_rx_ready = 1'b1;
      @(negedge clk);
      i_rx_ready = 1'b0;
      @(negedge clk);
    end
    checkOutput({tag, "/rx_empty"}, o_rx_valid, 0);
    checkOutput({tag, "/rx_level0"}, o_rx_level, 0);
  endtask

  task automatic runFrame(input bit cpol, input bit cpha, input bit lsb, input int nbits,
                          input string tag, input bit drain);
    n_under = 0; n_over = 0; n_ferr = 0;
    exp_under = 0; exp_over = 0; exp_ferr = 0;
    host_rx.delete();
    modelFrame(cpha, nbits);
    hostFrame(cpol, cpha, lsb, nbits);
    foreach (exp_cap[i])
      if (i < host_rx.size()) checkOutput({tag, "/miso_word"}, host_rx[i], exp_cap[i]);
    checkOutput({tag, "/tx_level"}, o_tx_level, tx_model.size());
    checkOutput({tag, "/rx_level"}, o_rx_level, rx_model.size());
    checkOutput({tag, "/underflow"}, n_under, exp_under);
    checkOutput({tag, "/overflow"}, n_over, exp_over);
    checkOutput({tag, "/frame_err"}, n_ferr, exp_ferr);
    checkOutput({tag, "/inactive"}, o_spi_active, 0);
    checkOutput({tag, "/miso_idle"}, o_spi_miso, 0);
    if (drain) drainRx(tag);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "/miso"}, o_spi_miso, 0);
    checkOutput({tag, "/rx_valid"}, o_rx_valid, 0);
    checkOutput({tag, "/rx_data"}, o_rx_data, 0);
    checkOutput({tag, "/tx_ready"}, o_tx_ready, 1);
    checkOutput({tag, "/tx_level"}, o_tx_level, 0);
    checkOutput({tag, "/rx_level"}, o_rx_level, 0);
    checkOutput({tag, "/pulses"}, {o_tx_underflow, o_rx_overflow, o_frame_err}, 0);
    checkOutput({tag, "/active"}, o_spi_active, 0);
  endtask

  initial begin
    int nw, npre, nbits;
    bit cp, ch, lb;
    logic [W-1:0] ovf_words[9];

    repeat (5) @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Underflow: TX empty, one word in mode 1.
    frame_words = '{16'h5A5A};
    runFrame(1'b0, 1'b1, 1'b0, W, "underflow", 1'b1);

    // Overflow: nine words with no reader.
    for (int i = 0; i < 9; i++) ovf_words[i] = W'(i + 1);
    frame_words.delete();
    foreach (ovf_words[i]) frame_words.push_back(ovf_words[i]);
    runFrame(1'b0, 1'b0, 1'b0, 9 * W, "overflow", 1'b1);

    // All modes and bit orders with a two-word burst.
    for (int m = 0; m < 4; m++) begin
      for (int l = 0; l < 2; l++) begin
        applyStimulus(16'hA5A5);
        applyStimulus(16'h1234);
        applyStimulus(16'h0000);
        frame_words = '{16'h3C5A, 16'hF00F};
        runFrame(m[1], m[0], l[0], 2 * W, $sformatf("mode%0d_lsb%0d", m, l), 1'b1);
      end
    end

    // Truncated frame followed by a full one.
    frame_words = '{16'h7777};
    runFrame(1'b0, 1'b0, 1'b0, 7, "truncated", 1'b1);
    frame_words = '{16'hBEEF};
    runFrame(1'b0, 1'b0, 1'b0, W, "after_trunc", 1'b1);

    // Randomized frames.
    for (int it = 0; it < 14; it++) begin
      cp = 1'($urandom); ch = 1'($urandom); lb = 1'($urandom);
      nw = $urandom_range(1, 3);
      npre = $urandom_range(0, DEPTH - tx_model.size());
      for (int k = 0; k < npre; k++) applyStimulus(W'($urandom));
      frame_words.delete();
      for (int k = 0; k <= nw; k++) frame_words.push_back(W'($urandom));
      nbits = nw * W + (($urandom % 4 == 0) ? $urandom_range(1, W - 1) : 0);
      runFrame(cp, ch, lb, nbits, $sformatf("rand%0d", it), 1'b1);
    end

    // Reset in the middle of the ninth bit.
    for (int k = 0; k < 3; k++) applyStimulus(W'($urandom));
    frame_words = '{16'h1111, 16'h2222};
    fork
      hostFrame(1'b0, 1'b0, 1'b0, 2 * W);
      begin
        @(negedge i_spi_cs_n);
        repeat (HALF + 16 * HALF + HALF / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tx_model.delete();
        rx_model.delete();
        checkResetValues("midreset");
      end
    join
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    applyStimulus(16'hCAFE);
    frame_words = '{16'hD00D};
    runFrame(1'b1, 1'b1, 1'b1, W, "post_reset", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
